// File: rtl/mips_dmem_ws.sv
// mips_dmem_ws: word-addressed data RAM with a req/ready handshake, programmable
// wait states, byte-lane writes and error reporting. It sits between the core's data
// port and storage, so the core can run against slow memory models unchanged.
//
// Optional feature: define DMEM_MMIO_EN to decode MMIO_ADDR to the mmio_out register.
// Without it, mmio_out is tied to zero and MMIO_ADDR is an ordinary out-of-range address.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-low reset
//   req        access request (level), sampled only while idle
//   we         1 = write, 0 = read; sampled with req
//   addr[31:0] byte address; sampled with req
//   be[3:0]    byte enables, be[i] -> writedata[8i+7:8i]; sampled with req
//   writedata  write data; sampled with req
//   readdata   read data, valid while ready=1 and err=0
//   ready      one-cycle response strobe
//   err        access error, valid with ready
//   busy       high while an access is in flight
//   mmio_out   MMIO output register
module mips_dmem_ws #(
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned WAIT_STATES = 2,
    parameter logic [31:0] MMIO_ADDR   = 32'hFFFF_FFF0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [3:0]  be,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        ready,
    output logic        err,
    output logic        busy,
    output logic [31:0] mmio_out
);

    localparam int unsigned IW    = $clog2(DEPTH);
    localparam int unsigned CW    = 4;
    localparam logic [31:0] LIMIT = 32'(DEPTH * 4);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    logic [31:0]   mem [DEPTH];
    state_t        state;
    logic [CW-1:0] cnt;

    // Copies of the request taken at acceptance; later input changes are ignored.
    logic          lat_we;
    logic [IW-1:0] lat_idx;
    logic [3:0]    lat_be;
    logic [31:0]   lat_wd;
    logic          lat_err;
    logic          lat_mmio;

    // Decode of the live request inputs.
    logic          in_mmio;
    logic          in_err;
    logic [IW-1:0] in_idx;

    // Access attributes used when entering RESP (live inputs on a zero-wait accept).
    logic          acc_we;
    logic [IW-1:0] acc_idx;
    logic          acc_err;
    logic          acc_mmio;
    logic [31:0]   resp_data;

    logic          commit;

`ifdef DMEM_MMIO_EN
    assign in_mmio = (addr == MMIO_ADDR);
`else
    logic unused_mmio_addr;
    assign unused_mmio_addr = ^MMIO_ADDR;
    assign in_mmio = 1'b0;
`endif

    assign in_idx = addr[IW+1:2];
    assign in_err = (addr[1:0] != 2'b00) || ((addr >= LIMIT) && !in_mmio);

    // Select the live request on a direct IDLE->RESP path, otherwise the latched one.
    always_comb begin
        acc_we   = lat_we;
        acc_idx  = lat_idx;
        acc_err  = lat_err;
        acc_mmio = lat_mmio;
        if (state == S_IDLE) begin
            acc_we   = we;
            acc_idx  = in_idx;
            acc_err  = in_err;
            acc_mmio = in_mmio;
        end
    end

    // Response word: zero for errors and writes, the MMIO register or the RAM word otherwise.
    always_comb begin
        resp_data = '0;
        if (!acc_err && !acc_we) begin
            resp_data = acc_mmio ? mmio_out : mem[acc_idx];
        end
    end

    // Write commit happens on the edge that ends RESP, unless reset is asserted.
    assign commit = rst && (state == S_RESP) && lat_we && !lat_err;

    // Request capture.
    always_ff @(posedge clk) begin
        if (!rst) begin
            lat_we   <= 1'b0;
            lat_idx  <= '0;
            lat_be   <= '0;
            lat_wd   <= '0;
            lat_err  <= 1'b0;
            lat_mmio <= 1'b0;
        end else if (state == S_IDLE && req) begin
            lat_we   <= we;
            lat_idx  <= in_idx;
            lat_be   <= be;
            lat_wd   <= writedata;
            lat_err  <= in_err;
            lat_mmio <= in_mmio;
        end
    end

    // Access sequencer: IDLE -> WAIT -> RESP -> IDLE with registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            ready    <= 1'b0;
            err      <= 1'b0;
            readdata <= '0;
            busy     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    ready    <= 1'b0;
                    err      <= 1'b0;
                    readdata <= '0;
                    if (req) begin
                        busy <= 1'b1;
                        if (WAIT_STATES == 0) begin
                            state    <= S_RESP;
                            ready    <= 1'b1;
                            err      <= acc_err;
                            readdata <= resp_data;
                        end else begin
                            state <= S_WAIT;
                            cnt   <= CW'(WAIT_STATES);
                        end
                    end
                end
                S_WAIT: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state    <= S_RESP;
                        ready    <= 1'b1;
                        err      <= acc_err;
                        readdata <= resp_data;
                    end
                end
                S_RESP: begin
                    state    <= S_IDLE;
                    ready    <= 1'b0;
                    err      <= 1'b0;
                    readdata <= '0;
                    busy     <= 1'b0;
                end
                default: begin
                    state    <= S_IDLE;
                    ready    <= 1'b0;
                    err      <= 1'b0;
                    readdata <= '0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

    // RAM byte-lane write; contents are deliberately not cleared by reset.
    always_ff @(posedge clk) begin
        if (commit && !lat_mmio) begin
            for (int i = 0; i < 4; i++) begin
                if (lat_be[i]) begin
                    mem[lat_idx][8*i +: 8] <= lat_wd[8*i +: 8];
                end
            end
        end
    end

`ifdef DMEM_MMIO_EN
    // MMIO output register, byte-lane writable.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mmio_out <= '0;
        end else if (commit && lat_mmio) begin
            for (int i = 0; i < 4; i++) begin
                if (lat_be[i]) begin
                    mmio_out[8*i +: 8] <= lat_wd[8*i +: 8];
                end
            end
        end
    end
`else
    assign mmio_out = '0;
`endif

endmodule

// File: tb/tb_mips_dmem_ws.sv
// tb_mips_dmem_ws: directed self-checking bench for mips_dmem_ws.
// dut uses WAIT_STATES=2, dut0 uses WAIT_STATES=0; both share the data-path inputs
// but have separate req lines. Expected responses go through a scoreboard queue.
module tb_mips_dmem_ws;

    localparam logic [31:0] MMIO = 32'hFFFF_FFF0;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        req0;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;

    logic [31:0] readdata, readdata0;
    logic        ready, ready0;
    logic        err, err0;
    logic        busy, busy0;
    logic [31:0] mmio_out, mmio_out0;

    int compared = 0;
    int mism     = 0;

    typedef struct {
        logic [31:0] rd;
        logic        er;
        bit          chk_rd;
    } exp_t;

    exp_t sb[$];

    mips_dmem_ws #(.DEPTH(64), .WAIT_STATES(2), .MMIO_ADDR(MMIO)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .be(be),
        .writedata(wd), .readdata(readdata), .ready(ready), .err(err),
        .busy(busy), .mmio_out(mmio_out)
    );

    mips_dmem_ws #(.DEPTH(64), .WAIT_STATES(0), .MMIO_ADDR(MMIO)) dut0 (
        .clk(clk), .rst(rst), .req(req0), .we(we), .addr(addr), .be(be),
        .writedata(wd), .readdata(readdata0), .ready(ready0), .err(err0),
        .busy(busy0), .mmio_out(mmio_out0)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mism++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One handshake: drive for one cycle, scramble inputs while busy, await ready.
    task automatic access(input bit sel, input bit w, input logic [31:0] a,
                          input logic [3:0] b, input logic [31:0] d,
                          input logic [31:0] exp_rd, input logic exp_er, input string tag);
        exp_t e;
        int   k;
        bit   got;
        e.rd     = exp_rd;
        e.er     = exp_er;
        e.chk_rd = !w || exp_er;
        sb.push_back(e);
        @(negedge clk);
        we = w; addr = a; be = b; wd = d;
        if (sel) req0 = 1'b1; else req = 1'b1;
        @(posedge clk);
        k   = 0;
        got = 1'b0;
        while (!got && k < 20) begin
            @(negedge clk);
            k++;
            req  = 1'b0;
            req0 = 1'b0;
            addr = $urandom;
            wd   = $urandom;
            be   = 4'(($urandom));
            we   = ~w;
            got  = sel ? ready0 : ready;
        end
        chk({tag, "_latency"}, 32'(k), sel ? 32'd1 : 32'd3);
        e = sb.pop_front();
        if (e.chk_rd) chk({tag, "_readdata"}, sel ? readdata0 : readdata, e.rd);
        chk({tag, "_err"}, 32'(sel ? err0 : err), 32'(e.er));
        @(negedge clk);
        chk({tag, "_strobe_off"}, 32'(sel ? ready0 : ready), 32'd0);
    endtask

    initial begin
        exp_t e;
        bit   pulsed;
        int   nxt;

        rst = 1'b0; req = 1'b0; req0 = 1'b0; we = 1'b0;
        addr = '0; be = '0; wd = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_readdata", readdata, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mmio", mmio_out, 32'd0);
        rst = 1'b1;

        // Reset in the middle of a write's wait phase drops the write.
        access(0, 1, 32'h10, 4'hF, 32'h0BAD_F00D, 32'h0, 1'b0, "pre_wr10");
        @(negedge clk);
        we = 1'b1; addr = 32'h10; be = 4'hF; wd = 32'hDEAD_BEEF; req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        rst = 1'b0;
        pulsed = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (ready) pulsed = 1'b1;
        end
        chk("midrst_ready", 32'(ready), 32'd0);
        chk("midrst_err", 32'(err), 32'd0);
        chk("midrst_readdata", readdata, 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        rst = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (ready) pulsed = 1'b1;
        end
        chk("midrst_no_pulse", 32'(pulsed), 32'd0);
        access(0, 0, 32'h10, 4'h0, 32'h0, 32'h0BAD_F00D, 1'b0, "rd10_after_rst");

        // Basic write/read with wait states.
        access(0, 1, 32'h08, 4'hF, 32'h1234_5678, 32'h0, 1'b0, "wr08");
        access(0, 0, 32'h08, 4'h0, 32'h0, 32'h1234_5678, 1'b0, "rd08");

        // Byte lanes.
        access(0, 1, 32'h00, 4'hF, 32'h1122_3344, 32'h0, 1'b0, "wr00_full");
        access(0, 1, 32'h00, 4'b0101, 32'hAABB_CCDD, 32'h0, 1'b0, "wr00_lanes");
        access(0, 0, 32'h00, 4'hF, 32'h0, 32'h11BB_33DD, 1'b0, "rd00_lanes");

        // Errors: misaligned read, out-of-range write aliasing word 0 must not land.
        access(0, 0, 32'h06, 4'hF, 32'h0, 32'h0, 1'b1, "rd06_misaligned");
        access(0, 1, 32'h100, 4'hF, 32'hFFFF_FFFF, 32'h0, 1'b1, "wr100_range");
        access(0, 0, 32'h00, 4'h0, 32'h0, 32'h11BB_33DD, 1'b0, "rd00_after_err");

        // No-op write and last word.
        access(0, 1, 32'h08, 4'h0, 32'hFFFF_FFFF, 32'h0, 1'b0, "wr08_be0");
        access(0, 0, 32'h08, 4'h0, 32'h0, 32'h1234_5678, 1'b0, "rd08_after_be0");
        access(0, 1, 32'hFC, 4'hF, 32'hCAFE_F00D, 32'h0, 1'b0, "wrFC");
        access(0, 0, 32'hFC, 4'h0, 32'h0, 32'hCAFE_F00D, 1'b0, "rdFC");

        // MMIO register.
`ifdef DMEM_MMIO_EN
        access(0, 1, MMIO, 4'hF, 32'h0000_00A5, 32'h0, 1'b0, "mmio_wr");
        chk("mmio_out_after_wr", mmio_out, 32'h0000_00A5);
        access(0, 0, MMIO, 4'h0, 32'h0, 32'h0000_00A5, 1'b0, "mmio_rd");
`else
        access(0, 1, MMIO, 4'hF, 32'h0000_00A5, 32'h0, 1'b1, "mmio_wr");
        chk("mmio_out_after_wr", mmio_out, 32'h0);
`endif

        // Zero wait states: preload, then four reads with req held high.
        for (int i = 0; i < 4; i++) begin
            access(1, 1, 32'(4 * i), 4'hF, 32'h1000_0000 + 32'(i), 32'h0, 1'b0, "ws0_wr");
        end
        access(1, 0, 32'h4, 4'h0, 32'h0, 32'h1000_0001, 1'b0, "ws0_rd_after_wr");

        @(negedge clk);
        we = 1'b0; be = 4'h0; addr = 32'h0; req0 = 1'b1;
        e.rd = 32'h1000_0000; e.er = 1'b0; e.chk_rd = 1'b1;
        sb.push_back(e);
        nxt = 1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("held_busy", 32'(busy0), (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("held_ready", 32'(ready0), (i % 2 == 0) ? 32'd1 : 32'd0);
            if (ready0) begin
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("held_readdata", readdata0, e.rd);
                end
                addr = $urandom;
            end else if (nxt < 4) begin
                addr = 32'(4 * nxt);
                e.rd = 32'h1000_0000 + 32'(nxt);
                sb.push_back(e);
                nxt++;
            end else begin
                req0 = 1'b0;
            end
        end
        req0 = 1'b0;
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
        $finish;
    end

endmodule
